// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds core/vga/periph resets, then releases them in order.
// Optional soft reset of vga/periph from RUN when RST_SEQ_SOFT_RST_EN is defined.
module rst_sequencer #(
    parameter int unsigned HOLD_CYC  = 16,
    parameter int unsigned STAGE_DLY = 8
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic sw_rst_req,
    output logic rst_core,
    output logic rst_vga,
    output logic rst_periph,
    output logic ready,
    output logic sw_rst_ack
);

    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] STAGE_LAST = 16'(STAGE_DLY - 1);

    typedef enum logic [2:0] {
        HOLD,
        REL_CORE,
        REL_VGA,
        RUN
`ifdef RST_SEQ_SOFT_RST_EN
        ,
        SOFT
`endif
    } state_t;

    state_t      state_q;
    state_t      nxt;
    logic [1:0]  sync_q;
    logic        sync_ok;
    logic [15:0] cnt_q;
    logic        ack_d;

    assign sync_ok = sync_q[1];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
        end else begin
            state_q <= nxt;
        end
    end

    // Counter only advances in timed states; it stops before wrapping.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else if (state_q != nxt) begin
            cnt_q <= 16'd0;
        end else if (sync_ok && state_q != RUN) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        nxt   = state_q;
        ack_d = 1'b0;
        unique case (state_q)
            HOLD: begin
                if (sync_ok && cnt_q == HOLD_LAST) begin
                    nxt = REL_CORE;
                end
            end
            REL_CORE: begin
                if (cnt_q == STAGE_LAST) begin
                    nxt = REL_VGA;
                end
            end
            REL_VGA: begin
                if (cnt_q == STAGE_LAST) begin
                    nxt = RUN;
                end
            end
            RUN: begin
`ifdef RST_SEQ_SOFT_RST_EN
                if (sw_rst_req) begin
                    nxt   = SOFT;
                    ack_d = 1'b1;
                end
`endif
            end
`ifdef RST_SEQ_SOFT_RST_EN
            SOFT: begin
                if (cnt_q == HOLD_LAST) begin
                    nxt = REL_VGA;
                end
            end
`endif
            default: nxt = HOLD;
        endcase
    end

`ifndef RST_SEQ_SOFT_RST_EN
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req;
`endif

    // Outputs decoded from next state so each one lands on the transition edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_core   <= 1'b1;
            rst_vga    <= 1'b1;
            rst_periph <= 1'b1;
            ready      <= 1'b0;
            sw_rst_ack <= 1'b0;
        end else begin
            rst_core   <= (nxt == HOLD);
            rst_vga    <= (nxt == HOLD) || (nxt == REL_CORE)
`ifdef RST_SEQ_SOFT_RST_EN
                          || (nxt == SOFT)
`endif
                          ;
            rst_periph <= (nxt != RUN);
            ready      <= (nxt == RUN);
            sw_rst_ack <= ack_d;
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default instance plus HOLD_CYC=1/STAGE_DLY=1 instance.
// Expected release edges are queued at stimulus time and popped when observed.
`timescale 1ns/100ps
module tb_rst_sequencer;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_req0 = 1'b0;
    logic sw_req1 = 1'b0;
    logic core0, vga0, per0, rdy0, ack0;
    logic core1, vga1, per1, rdy1, ack1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int m_core[2], m_vga[2], m_per[2], m_rdy[2];
    bit m_viol[2];

    always #5 pclk = ~pclk;

    rst_sequencer dut0 (
        .pclk(pclk), .rst_n(rst_n), .sw_rst_req(sw_req0),
        .rst_core(core0), .rst_vga(vga0), .rst_periph(per0),
        .ready(rdy0), .sw_rst_ack(ack0)
    );

    rst_sequencer #(.HOLD_CYC(1), .STAGE_DLY(1)) dut1 (
        .pclk(pclk), .rst_n(rst_n), .sw_rst_req(sw_req1),
        .rst_core(core1), .rst_vga(vga1), .rst_periph(per1),
        .ready(rdy1), .sw_rst_ack(ack1)
    );

    task automatic push_release();
        exp_q.push_back(18); exp_q.push_back(26);
        exp_q.push_back(34); exp_q.push_back(34);
        exp_q.push_back(3);  exp_q.push_back(4);
        exp_q.push_back(5);  exp_q.push_back(5);
    endtask

    // Records the edge (counted from rst_n rise) at which each output releases.
    task automatic observe(input int limit);
        for (int d = 0; d < 2; d++) begin
            m_core[d] = -1; m_vga[d] = -1; m_per[d] = -1; m_rdy[d] = -1;
            m_viol[d] = 1'b0;
        end
        for (int k = 1; k <= limit; k++) begin
            @(posedge pclk); #1;
            for (int d = 0; d < 2; d++) begin
                logic c, v, p, r;
                c = (d == 0) ? core0 : core1;
                v = (d == 0) ? vga0  : vga1;
                p = (d == 0) ? per0  : per1;
                r = (d == 0) ? rdy0  : rdy1;
                if (!c && m_core[d] < 0) m_core[d] = k;
                if (c && m_core[d] >= 0) m_viol[d] = 1'b1;
                if (!v && m_vga[d] < 0) m_vga[d] = k;
                if (v && m_vga[d] >= 0) m_viol[d] = 1'b1;
                if (!p && m_per[d] < 0) m_per[d] = k;
                if (p && m_per[d] >= 0) m_viol[d] = 1'b1;
                if (r && m_rdy[d] < 0) m_rdy[d] = k;
                if (!r && m_rdy[d] >= 0) m_viol[d] = 1'b1;
                if (!v && c) m_viol[d] = 1'b1;
                if (!p && v) m_viol[d] = 1'b1;
                if (r == p) m_viol[d] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge pclk);
        #1;
        n_cmp++;
        if ({core0, vga0, per0, rdy0, ack0} !== 5'b11100) begin
            n_bad++;
            $display("FAIL reset_dut0 got %b want 11100",
                     {core0, vga0, per0, rdy0, ack0});
        end
        n_cmp++;
        if ({core1, vga1, per1, rdy1, ack1} !== 5'b11100) begin
            n_bad++;
            $display("FAIL reset_dut1 got %b want 11100",
                     {core1, vga1, per1, rdy1, ack1});
        end
    endtask

    task automatic test_release();
        @(negedge pclk);
        push_release();
        rst_n = 1'b1;
        observe(60);
        for (int d = 0; d < 2; d++) begin
            int got[4];
            got = '{m_core[d], m_vga[d], m_per[d], m_rdy[d]};
            for (int i = 0; i < 4; i++) begin
                int e;
                e = exp_q.pop_front();
                n_cmp++;
                if (got[i] !== e) begin
                    n_bad++;
                    $display("FAIL release_dut%0d_out%0d edge %0d want %0d",
                             d, i, got[i], e);
                end
            end
            n_cmp++;
            if (m_viol[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL release_order_dut%0d viol %0d want 0",
                         d, m_viol[d]);
            end
        end
    endtask

    task automatic test_short_pulse();
        @(posedge pclk);
        #3 rst_n = 1'b0;
        #0.5;
        n_cmp++;
        if ({core0, vga0, per0, rdy0, core1, vga1, per1, rdy1} !== 8'b11101110) begin
            n_bad++;
            $display("FAIL pulse_async got %b want 11101110",
                     {core0, vga0, per0, rdy0, core1, vga1, per1, rdy1});
        end
        push_release();
        #0.5 rst_n = 1'b1;
        observe(60);
        for (int d = 0; d < 2; d++) begin
            int got[4];
            got = '{m_core[d], m_vga[d], m_per[d], m_rdy[d]};
            for (int i = 0; i < 4; i++) begin
                int e;
                e = exp_q.pop_front();
                n_cmp++;
                if (got[i] !== e) begin
                    n_bad++;
                    $display("FAIL pulse_dut%0d_out%0d edge %0d want %0d",
                             d, i, got[i], e);
                end
            end
        end
    endtask

    task automatic test_mid_release();
        rst_n = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (22) @(posedge pclk);
        #1;
        n_cmp++;
        if ({core0, vga0} !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_before got %b want 01", {core0, vga0});
        end
        rst_n = 1'b0;
        #0.5;
        n_cmp++;
        if ({core0, vga0, per0, rdy0} !== 4'b1110) begin
            n_bad++;
            $display("FAIL mid_reassert got %b want 1110",
                     {core0, vga0, per0, rdy0});
        end
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        push_release();
        rst_n = 1'b1;
        observe(60);
        for (int d = 0; d < 2; d++) begin
            int got[4];
            got = '{m_core[d], m_vga[d], m_per[d], m_rdy[d]};
            for (int i = 0; i < 4; i++) begin
                int e;
                e = exp_q.pop_front();
                n_cmp++;
                if (got[i] !== e) begin
                    n_bad++;
                    $display("FAIL mid_dut%0d_out%0d edge %0d want %0d",
                             d, i, got[i], e);
                end
            end
        end
    endtask

`ifdef RST_SEQ_SOFT_RST_EN
    task automatic test_soft();
        int acks, vfall, pfall, rrise;
        bit core_bad;
        acks = 0; vfall = -1; pfall = -1; rrise = -1; core_bad = 1'b0;
        exp_q.push_back(16); exp_q.push_back(24);
        exp_q.push_back(24); exp_q.push_back(0);
        @(negedge pclk);
        sw_req0 = 1'b1;
        @(posedge pclk); #1;
        n_cmp++;
        if ({core0, vga0, per0, rdy0, ack0} !== 5'b01101) begin
            n_bad++;
            $display("FAIL soft_entry got %b want 01101",
                     {core0, vga0, per0, rdy0, ack0});
        end
        @(negedge pclk);
        sw_req0 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge pclk); #1;
            if (ack0) acks++;
            if (core0) core_bad = 1'b1;
            if (!vga0 && vfall < 0) vfall = k;
            if (!per0 && pfall < 0) pfall = k;
            if (rdy0 && rrise < 0) rrise = k;
        end
        begin
            int got[4];
            got = '{vfall, pfall, rrise, acks};
            for (int i = 0; i < 4; i++) begin
                int e;
                e = exp_q.pop_front();
                n_cmp++;
                if (got[i] !== e) begin
                    n_bad++;
                    $display("FAIL soft_item%0d got %0d want %0d", i, got[i], e);
                end
            end
        end
        n_cmp++;
        if (core_bad !== 1'b0) begin
            n_bad++;
            $display("FAIL soft_core got %0d want 0", core_bad);
        end
    endtask
`else
    task automatic test_sw_ignored();
        @(negedge pclk);
        sw_req0 = 1'b1;
        sw_req1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(32'b0001000010);
            @(posedge pclk); #1;
            begin
                int e;
                e = exp_q.pop_front();
                n_cmp++;
                if ({22'd0, core0, vga0, per0, rdy0, ack0,
                     core1, vga1, per1, rdy1, ack1} !== e) begin
                    n_bad++;
                    $display("FAIL sw_ignored cyc %0d got %b want %b", k,
                             {core0, vga0, per0, rdy0, ack0,
                              core1, vga1, per1, rdy1, ack1}, e[9:0]);
                end
            end
        end
        sw_req0 = 1'b0;
        sw_req1 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_release();
`ifdef RST_SEQ_SOFT_RST_EN
        test_soft();
`else
        test_sw_ignored();
`endif
        test_short_pulse();
        test_mid_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter HOLD_CYC, default 16, number of pclk cycles all resets are held after reset release; legal range 1..65535.
REQ-002 Parameter STAGE_DLY, default 8, number of pclk cycles between successive stage releases; legal range 1..65535.
REQ-003 pclk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset, driven from the inverted output of the clock/lock reset generator.
REQ-005 sw_rst_req  input  1  level-sensitive soft-reset request, synchronous to pclk.
REQ-006 rst_core  output  1  active-high reset for core logic.
REQ-007 rst_vga  output  1  active-high reset for the display pipeline.
REQ-008 rst_periph  output  1  active-high reset for peripherals.
REQ-009 ready  output  1  high only when all stages are released (state RUN).
REQ-010 sw_rst_ack  output  1  one-cycle pulse acknowledging an accepted soft-reset request.

Function
REQ-011 rst_n SHALL pass through a 2-flop synchronizer: assertion immediate (async), deassertion seen internally on the 2nd pclk rising edge after rst_n rises.
REQ-012 FSM states SHALL be HOLD, REL_CORE, REL_VGA, REL_PERIPH/RUN, SOFT; one 16-bit cycle counter, cleared on every state change.
REQ-013 HOLD: all three resets high, ready low; counter increments each cycle; at count HOLD_CYC-1 -> REL_CORE.
REQ-014 Entering REL_CORE, rst_core SHALL fall on that same edge; at count STAGE_DLY-1 -> REL_VGA, rst_vga falls on that edge.
REQ-015 In REL_VGA at count STAGE_DLY-1 -> RUN; rst_periph falls and ready rises on that edge.
REQ-016 Release order SHALL be strictly core, vga, periph; no output SHALL deassert out of order or reassert except via reset or SOFT.
REQ-017 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-018 RUN SHALL persist indefinitely absent rst_n assertion or an accepted soft reset.
REQ-019 Counter SHALL never wrap; compare values are parameter-bounded to 16 bits.

Reset
REQ-020 While rst_n low: rst_core=1, rst_vga=1, rst_periph=1, ready=0, sw_rst_ack=0, state=HOLD, counter=0, synchronizer flops=0.
REQ-021 rst_n asserted in any state (including SOFT or mid-release) SHALL asynchronously return all outputs to REQ-020 values within the same cycle and restart the full sequence on release.
REQ-022 A rst_n pulse shorter than one pclk period SHALL still produce a full HOLD sequence.

Configuration
REQ-023 Macro RST_SEQ_SOFT_RST_EN defined: in RUN, sw_rst_req=1 sampled on an edge -> state SOFT on that edge; rst_vga and rst_periph rise, ready falls, sw_rst_ack=1 for exactly that one cycle; rst_core stays low.
REQ-024 With RST_SEQ_SOFT_RST_EN, SOFT holds HOLD_CYC cycles then -> REL_CORE-equivalent path starting at rst_vga release: rst_vga falls HOLD_CYC edges after SOFT entry, rst_periph/ready STAGE_DLY edges later.
REQ-025 With RST_SEQ_SOFT_RST_EN, sw_rst_req SHALL be ignored outside RUN; a request held high continuously re-triggers only after RUN is re-entered.
REQ-026 Without RST_SEQ_SOFT_RST_EN: SOFT state absent, sw_rst_req port present but ignored, sw_rst_ack tied 0.

Verification
REQ-027 Defaults, rst_n low 5 cycles then high -> rst_core falls edge 18, rst_vga edge 26, rst_periph and ready edge 34 (edges counted from rst_n rise).
REQ-028 rst_n pulsed low 1 ns asynchronously while in RUN -> all resets high, ready 0 immediately; sequence replays with REQ-027 timing.
REQ-029 rst_n asserted at edge 22 (between core and vga release) -> rst_core reasserts immediately; restart timing per REQ-027.
REQ-030 HOLD_CYC=1, STAGE_DLY=1 -> rst_core edge 3, rst_vga edge 4, rst_periph/ready edge 5.
REQ-031 RST_SEQ_SOFT_RST_EN defined, defaults, sw_rst_req high 1 cycle in RUN -> sw_rst_ack one pulse, rst_core stays 0, rst_vga falls 16 edges later, rst_periph/ready 8 edges after that.
REQ-032 RST_SEQ_SOFT_RST_EN undefined, sw_rst_req held high in RUN -> outputs unchanged, sw_rst_ack constant 0.
